// File: rtl/mono_readout_emulator.sv
// LF-Monopix2 readout periphery emulator: hit FIFO, TOKEN, serial DATA_OUT.
// Optional MONO_EMU_GRAY_EN: LE/TE fields serialised as Gray code.
module mono_readout_emulator #(
    parameter int COL_BITS   = 6,
    parameter int ROW_BITS   = 9,
    parameter int TS_BITS    = 6,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_hit_wr,
    input  logic [COL_BITS-1:0] i_hit_col,
    input  logic [ROW_BITS-1:0] i_hit_row,
    input  logic [TS_BITS-1:0]  i_hit_le,
    input  logic [TS_BITS-1:0]  i_hit_te,
    output logic                o_hit_full,
    input  logic                i_freeze,
    input  logic                i_read,
    output logic                o_token,
    output logic                o_data_out,
    output logic                o_busy,
    output logic                o_read_err,
    output logic [7:0]          o_lost_cnt
);

    localparam int WORD_BITS = COL_BITS + ROW_BITS + 2 * TS_BITS;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int PW        = DEPTH_LOG2 + 1;
    localparam int CW        = $clog2(WORD_BITS);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                r_state;
    logic [WORD_BITS-1:0]  r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_frozen_cnt;
    logic                  r_freeze_d;
    logic                  r_read_d;
    logic                  r_rd_req;
    logic                  r_token;
    logic                  r_data;
    logic                  r_busy;
    logic                  r_err;
    logic [7:0]            r_lost;
    logic [WORD_BITS-1:0]  r_sr;
    logic [CW-1:0]         r_bit_cnt;

    logic [PW-1:0]         w_occ;
    logic [PW-1:0]         w_occ_nxt;
    logic [PW-1:0]         w_frozen_nxt;
    logic                  w_full;
    logic                  w_wr_ok;
    logic                  w_pop;
    logic                  w_frz_rise;
    logic                  w_token_nxt;
    logic [WORD_BITS-1:0]  w_head;
    logic [TS_BITS-1:0]    w_le;
    logic [TS_BITS-1:0]    w_te;
    logic [WORD_BITS-1:0]  w_load;

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_occ == PW'(DEPTH));
    assign w_wr_ok    = i_hit_wr & ~w_full;
    assign w_pop      = (r_state == S_IDLE) & r_rd_req & r_token;
    assign w_occ_nxt  = w_occ + PW'(w_wr_ok) - PW'(w_pop);
    assign w_frz_rise = i_freeze & ~r_freeze_d;

    // Snapshot on the rising edge excludes a hit popped in the same cycle
    always_comb begin
        w_frozen_nxt = r_frozen_cnt;
        if (!i_freeze)
            w_frozen_nxt = '0;
        else if (w_frz_rise)
            w_frozen_nxt = w_occ - PW'(w_pop);
        else if (w_pop)
            w_frozen_nxt = r_frozen_cnt - PW'(1);
    end

    assign w_token_nxt = i_freeze ? (w_frozen_nxt != '0)
                                  : (w_occ_nxt != '0);

    assign w_head = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
`ifdef MONO_EMU_GRAY_EN
    assign w_le = w_head[TS_BITS-1:0] ^ (w_head[TS_BITS-1:0] >> 1);
    assign w_te = w_head[2*TS_BITS-1:TS_BITS]
                ^ (w_head[2*TS_BITS-1:TS_BITS] >> 1);
`else
    assign w_le = w_head[TS_BITS-1:0];
    assign w_te = w_head[2*TS_BITS-1:TS_BITS];
`endif
    assign w_load = {w_head[WORD_BITS-1:2*TS_BITS], w_te, w_le};

    always_ff @(posedge i_clk) begin
        if (w_wr_ok)
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <=
                {i_hit_col, i_hit_row, i_hit_te, i_hit_le};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_frozen_cnt <= '0;
            r_freeze_d   <= 1'b0;
            r_read_d     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_token      <= 1'b0;
            r_data       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_lost       <= '0;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
        end else begin
            r_read_d     <= i_read;
            r_rd_req     <= i_read & ~r_read_d;
            r_freeze_d   <= i_freeze;
            r_frozen_cnt <= w_frozen_nxt;
            r_token      <= w_token_nxt;
            r_err        <= 1'b0;
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (i_hit_wr && w_full && (r_lost != 8'hFF))
                r_lost <= r_lost + 8'd1;
            unique case (r_state)
                S_IDLE: begin
                    if (r_rd_req) begin
                        if (r_token) begin
                            r_sr      <= w_load;
                            r_data    <= w_load[WORD_BITS-1];
                            r_bit_cnt <= CW'(WORD_BITS - 1);
                            r_busy    <= 1'b1;
                            r_state   <= S_SHIFT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_rd_req)
                        r_err <= 1'b1;
                    if (r_bit_cnt == '0) begin
                        r_data  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Rotate so every bit stays live; next bit is sr[MSB-1]
                        r_sr      <= {r_sr[WORD_BITS-2:0], r_sr[WORD_BITS-1]};
                        r_data    <= r_sr[WORD_BITS-2];
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign o_hit_full = w_full;
    assign o_token    = r_token;
    assign o_data_out = r_data;
    assign o_busy     = r_busy;
    assign o_read_err = r_err;
    assign o_lost_cnt = r_lost;

endmodule

// File: tb/tb_mono_readout_emulator.sv
// Testbench for mono_readout_emulator: queue-based model, random hits.
// Build with MONO_EMU_GRAY_EN to check the Gray-coded timestamp variant.
module tb_mono_readout_emulator;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_hit_wr;
    logic [5:0]  i_hit_col;
    logic [8:0]  i_hit_row;
    logic [5:0]  i_hit_le;
    logic [5:0]  i_hit_te;
    logic        o_hit_full;
    logic        i_freeze;
    logic        i_read;
    logic        o_token;
    logic        o_data_out;
    logic        o_busy;
    logic        o_read_err;
    logic [7:0]  o_lost_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [26:0] q[$];
    int          frozen;
    int          lost;
    logic        frz;

    always #5 clk = ~clk;

    mono_readout_emulator dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_hit_wr   (i_hit_wr),
        .i_hit_col  (i_hit_col),
        .i_hit_row  (i_hit_row),
        .i_hit_le   (i_hit_le),
        .i_hit_te   (i_hit_te),
        .o_hit_full (o_hit_full),
        .i_freeze   (i_freeze),
        .i_read     (i_read),
        .o_token    (o_token),
        .o_data_out (o_data_out),
        .o_busy     (o_busy),
        .o_read_err (o_read_err),
        .o_lost_cnt (o_lost_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] to_gray(input logic [5:0] b);
        logic [5:0] g;
        for (int i = 0; i < 6; i++)
            g[i] = (i == 5) ? b[i] : (b[i] != b[i+1]);
        return g;
    endfunction

    // Expected serial word for a stored {col,row,te,le} hit
    function automatic logic [26:0] exp_ser(input logic [26:0] h);
        logic [5:0] l;
        logic [5:0] t;
        l = h[5:0];
        t = h[11:6];
`ifdef MONO_EMU_GRAY_EN
        l = to_gray(l);
        t = to_gray(t);
`endif
        return {h[26:12], t, l};
    endfunction

    function automatic logic exp_token();
        return frz ? (frozen != 0) : (q.size() != 0);
    endfunction

    function automatic logic [26:0] model_pop();
        logic [26:0] h;
        h = q.pop_front();
        if (frz)
            frozen--;
        return exp_ser(h);
    endfunction

    task automatic do_reset();
        i_reset  = 1'b1;
        i_hit_wr = 1'b0;
        i_freeze = 1'b0;
        i_read   = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        q.delete();
        frozen = 0;
        lost   = 0;
        frz    = 1'b0;
    endtask

    task automatic set_freeze(input logic v);
        if (v && !frz)
            frozen = q.size();
        if (!v)
            frozen = 0;
        frz      = v;
        i_freeze = v;
        tick();
    endtask

    task automatic write_hit(input logic [5:0] c, input logic [8:0] r,
                             input logic [5:0] l, input logic [5:0] t);
        i_hit_col = c;
        i_hit_row = r;
        i_hit_le  = l;
        i_hit_te  = t;
        i_hit_wr  = 1'b1;
        tick();
        i_hit_wr = 1'b0;
        if (q.size() < 16)
            q.push_back({c, r, t, l});
        else if (lost < 255)
            lost++;
    endtask

    task automatic write_rand();
        write_hit(6'($urandom), 9'($urandom), 6'($urandom), 6'($urandom));
    endtask

    // One READ pulse; optionally a second pulse while bit err_at is on the line
    task automatic read_word(input int err_at, output logic [26:0] w,
                             output int busy_n, output int err_n,
                             output logic tok_load, output logic idle_ok);
        busy_n = 0;
        err_n  = 0;
        w      = '0;
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        for (int b = 26; b >= 0; b--) begin
            tick();
            w[b] = o_data_out;
            if (b == 26)
                tok_load = o_token;
            if (o_busy)
                busy_n++;
            if (o_read_err)
                err_n++;
            i_read = (b == err_at);
        end
        i_read = 1'b0;
        tick();
        if (o_read_err)
            err_n++;
        idle_ok = !o_busy && !o_data_out;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_hit_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full got %b want 0", o_hit_full);
        end
        n_checks++;
        if (o_token !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_token got %b want 0", o_token);
        end
        n_checks++;
        if (o_data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got %b want 0", o_data_out);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", o_busy);
        end
        n_checks++;
        if (o_read_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got %b want 0", o_read_err);
        end
        n_checks++;
        if (o_lost_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_lost got %0d want 0", o_lost_cnt);
        end
    endtask

    task automatic test_basic();
        logic [26:0] w, e, k;
        int bn, en;
        logic tl, io;
`ifdef MONO_EMU_GRAY_EN
        k = 27'b000101_001100100_001111_000010;
`else
        k = 27'b000101_001100100_001010_000011;
`endif
        do_reset();
        write_hit(6'd5, 9'd100, 6'd3, 6'd10);
        set_freeze(1'b1);
        n_checks++;
        if (o_token !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_token got %b want 1", o_token);
        end
        e = model_pop();
        read_word(-1, w, bn, en, tl, io);
        n_checks++;
        if (w !== k) begin
            n_fail++;
            $display("FAIL basic_word got %b want %b", w, k);
        end
        n_checks++;
        if (w !== e) begin
            n_fail++;
            $display("FAIL basic_model got %b want %b", w, e);
        end
        n_checks++;
        if (tl !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_tok_load got %b want 0", tl);
        end
        n_checks++;
        if (bn !== 27) begin
            n_fail++;
            $display("FAIL basic_busy_len got %0d want 27", bn);
        end
        n_checks++;
        if (io !== 1'b1 || en !== 0) begin
            n_fail++;
            $display("FAIL basic_idle got idle=%b err=%0d want 1 0", io, en);
        end
        set_freeze(1'b0);
    endtask

    task automatic test_freeze();
        logic [26:0] w, e;
        int bn, en;
        logic tl, io;
        do_reset();
        repeat (3) write_rand();
        set_freeze(1'b1);
        repeat (2) write_rand();
        for (int i = 0; i < 3; i++) begin
            e = model_pop();
            read_word(-1, w, bn, en, tl, io);
            n_checks++;
            if (w !== e || tl !== exp_token()) begin
                n_fail++;
                $display("FAIL frz_word%0d got %h tok %b want %h tok %b",
                         i, w, tl, e, exp_token());
            end
        end
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        tick();
        n_checks++;
        if (o_read_err !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frz_err got err=%b busy=%b want 1 0",
                     o_read_err, o_busy);
        end
        set_freeze(1'b0);
        n_checks++;
        if (o_token !== 1'b1) begin
            n_fail++;
            $display("FAIL frz_release got %b want 1", o_token);
        end
        for (int i = 0; i < 2; i++) begin
            e = model_pop();
            read_word(-1, w, bn, en, tl, io);
            n_checks++;
            if (w !== e) begin
                n_fail++;
                $display("FAIL frz_rest%0d got %h want %h", i, w, e);
            end
        end
        n_checks++;
        if (o_token !== 1'b0) begin
            n_fail++;
            $display("FAIL frz_empty got %b want 0", o_token);
        end
    endtask

    task automatic test_full();
        logic [26:0] w, e;
        int bn, en;
        logic tl, io;
        int bad;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            write_rand();
            if (i == 14 || i == 15) begin
                n_checks++;
                if (o_hit_full !== (i == 15)) begin
                    n_fail++;
                    $display("FAIL full_flag%0d got %b want %b",
                             i, o_hit_full, (i == 15));
                end
            end
        end
        n_checks++;
        if (o_lost_cnt !== 8'(lost) || lost != 3) begin
            n_fail++;
            $display("FAIL full_lost got %0d want 3", o_lost_cnt);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            e = model_pop();
            read_word(-1, w, bn, en, tl, io);
            if (w !== e)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_order got %0d bad words want 0", bad);
        end
        n_checks++;
        if (o_hit_full !== 1'b0 || o_token !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained got full=%b tok=%b want 0 0",
                     o_hit_full, o_token);
        end
        repeat (316) write_rand();
        n_checks++;
        if (o_lost_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL full_sat got %0d want 255", o_lost_cnt);
        end
    endtask

    task automatic test_reset_mid();
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        repeat (11) tick();
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy got %b want 1", o_busy);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        q.delete();
        frozen = 0;
        lost   = 0;
        n_checks++;
        if (o_data_out !== 1'b0 || o_busy !== 1'b0 || o_token !== 1'b0 ||
            o_hit_full !== 1'b0 || o_lost_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_state got d=%b b=%b t=%b f=%b l=%0d want 0",
                     o_data_out, o_busy, o_token, o_hit_full, o_lost_cnt);
        end
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        tick();
        n_checks++;
        if (o_read_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_empty got err=%b want 1", o_read_err);
        end
    endtask

    task automatic test_read_err();
        logic [26:0] w, e;
        int bn, en;
        logic tl, io;
        do_reset();
        write_rand();
        e = model_pop();
        read_word(15, w, bn, en, tl, io);
        n_checks++;
        if (w !== e || bn != 27) begin
            n_fail++;
            $display("FAIL rderr_word got %h busy %0d want %h 27", w, bn, e);
        end
        n_checks++;
        if (en != 1) begin
            n_fail++;
            $display("FAIL rderr_shift got %0d pulses want 1", en);
        end
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        tick();
        n_checks++;
        if (o_read_err !== 1'b1 || o_data_out !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rderr_idle got e=%b d=%b b=%b want 1 0 0",
                     o_read_err, o_data_out, o_busy);
        end
        tick();
        n_checks++;
        if (o_read_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rderr_pulse got %b want 0", o_read_err);
        end
    endtask

    task automatic test_random();
        logic [26:0] w, e;
        int bn, en;
        logic tl, io;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0)
                set_freeze(!frz);
            repeat ($urandom_range(0, 3)) write_rand();
            n_checks++;
            if (o_token !== exp_token() || o_hit_full !== (q.size() == 16) ||
                o_lost_cnt !== 8'(lost)) begin
                n_fail++;
                $display("FAIL rnd_state%0d got t=%b f=%b l=%0d want %b %b %0d",
                         it, o_token, o_hit_full, o_lost_cnt,
                         exp_token(), (q.size() == 16), lost);
            end
            if (exp_token()) begin
                e = model_pop();
                read_word(-1, w, bn, en, tl, io);
                n_checks++;
                if (w !== e || en != 0) begin
                    n_fail++;
                    $display("FAIL rnd_word%0d got %h err %0d want %h 0",
                             it, w, en, e);
                end
            end else begin
                i_read = 1'b1;
                tick();
                i_read = 1'b0;
                tick();
                n_checks++;
                if (o_read_err !== 1'b1 || o_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_err%0d got e=%b b=%b want 1 0",
                             it, o_read_err, o_busy);
                end
            end
        end
    endtask

    initial begin
        i_reset   = 1'b1;
        i_hit_wr  = 1'b0;
        i_hit_col = '0;
        i_hit_row = '0;
        i_hit_le  = '0;
        i_hit_te  = '0;
        i_freeze  = 1'b0;
        i_read    = 1'b0;
        test_reset();
        test_basic();
        test_freeze();
        test_full();
        test_reset_mid();
        test_read_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
